// File: rtl/lcd_num_writer_if.sv
// Signal bundle between the calculator datapath, lcd_num_writer and the LCD controller.
// The master drives the request and MBusy; lcd_num_writer is the slave.
interface lcd_num_writer_if;
    logic               start;
    logic signed [15:0] value;
    logic               busy;
    logic               done;
    logic               MBusy;
    logic        [7:0]  Lcd_data;
    logic               lcdstrb;

    modport master (
        output start, value, MBusy,
        input  busy, done, Lcd_data, lcdstrb
    );

    modport slave (
        input  start, value, MBusy,
        output busy, done, Lcd_data, lcdstrb
    );
endinterface

// File: rtl/lcd_num_writer.sv
// Converts a signed 16-bit result to decimal using a sequential double-dabble.
// Streams clear, an optional '-', and the digits to the LCD controller, paced by MBusy.
module lcd_num_writer #(
    parameter int unsigned SETTLE   = 8,
    parameter logic [7:0]  CLR_CODE = 8'h58
) (
    input  logic CLK_27,
    input  logic RESET,
    lcd_num_writer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CONV, SEND_CLR, SEND_SIGN, SEND_DIG, FINISH} state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t      state_q;
    logic [7:0]  settle_q;
    logic [7:0]  settle_d;
    logic        settle_ok;
    logic        neg_q;
    logic [15:0] mag_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [3:0]  iter_q;
    logic [2:0]  ptr_q;
    logic        nz_seen_q;
    logic [3:0]  digit;
    logic [7:0]  lcd_data_q;
    logic        lcdstrb_q;
    logic        busy_q;
    logic        done_q;

    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    // The strobe decision looks at the count including this cycle, so consecutive
    // strobes land exactly SETTLE+1 cycles apart when MBusy stays low.
    always_comb begin
        settle_d = settle_q;
        if (bus.MBusy || lcdstrb_q) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_C) begin
            settle_d = settle_q + 8'd1;
        end
    end

    assign settle_ok = (settle_d == SETTLE_C);
    assign bcd_adj   = dabble_adj(bcd_q);

    always_comb begin
        digit = bcd_q[3:0];
        case (ptr_q)
            3'd1:    digit = bcd_q[7:4];
            3'd2:    digit = bcd_q[11:8];
            3'd3:    digit = bcd_q[15:12];
            3'd4:    digit = bcd_q[19:16];
            default: digit = bcd_q[3:0];
        endcase
    end

    always_ff @(posedge CLK_27) begin
        if (RESET) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            neg_q      <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ptr_q      <= '0;
            nz_seen_q  <= 1'b0;
            lcd_data_q <= 8'h00;
            lcdstrb_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            settle_q  <= settle_d;
            lcdstrb_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        neg_q     <= bus.value[15];
                        mag_q     <= bus.value[15] ? $unsigned(-bus.value) : $unsigned(bus.value);
                        bcd_q     <= '0;
                        iter_q    <= '0;
                        ptr_q     <= 3'd4;
                        nz_seen_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    iter_q         <= iter_q + 4'd1;
                    if (iter_q == 4'd15) state_q <= SEND_CLR;
                end
                SEND_CLR: begin
                    if (settle_ok) begin
                        lcd_data_q <= CLR_CODE;
                        lcdstrb_q  <= 1'b1;
                        state_q    <= neg_q ? SEND_SIGN : SEND_DIG;
                    end
                end
                SEND_SIGN: begin
                    if (settle_ok) begin
                        lcd_data_q <= 8'h2D;
                        lcdstrb_q  <= 1'b1;
                        state_q    <= SEND_DIG;
                    end
                end
                SEND_DIG: begin
                    // Leading zeros above the units digit are dropped without waiting.
                    if (!nz_seen_q && ptr_q != 3'd0 && digit == 4'd0) begin
                        ptr_q <= ptr_q - 3'd1;
                    end else if (settle_ok) begin
                        lcd_data_q <= {4'h3, digit};
                        lcdstrb_q  <= 1'b1;
                        nz_seen_q  <= 1'b1;
                        if (ptr_q == 3'd0) state_q <= FINISH;
                        else               ptr_q   <= ptr_q - 3'd1;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Lcd_data = lcd_data_q;
    assign bus.lcdstrb  = lcdstrb_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_lcd_num_writer.sv
// Directed bench for lcd_num_writer: character streams, pacing against an LCD
// controller model, start filtering, and reset abandonment.
module tb_lcd_num_writer;
    logic CLK_27 = 1'b0;
    logic RESET  = 1'b1;

    lcd_num_writer_if bus ();

    lcd_num_writer #(.SETTLE(8), .CLR_CODE(8'h58)) dut (
        .CLK_27 (CLK_27),
        .RESET  (RESET),
        .bus    (bus.slave)
    );

    always #5 CLK_27 = ~CLK_27;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;       // 0: MBusy low, 1: controller model, 2: MBusy stuck high
    int kcnt   = 1000;
    int done_cnt  = 0;
    int consec_err = 0;
    bit prev_strb = 1'b0;
    logic [7:0] strb_data [$];
    int         strb_cyc  [$];
    logic [7:0] exp_q [$];

    always @(posedge CLK_27) cyc <= cyc + 1;

    // Controller model: busy for 50 cycles starting one cycle after a strobe,
    // with a 3-cycle low glitch in the middle.
    always @(negedge CLK_27) begin
        if (bus.lcdstrb) kcnt = 0;
        else if (kcnt < 1000) kcnt = kcnt + 1;
        if (mode == 2)      bus.MBusy = 1'b1;
        else if (mode == 1) bus.MBusy = (kcnt >= 1 && kcnt <= 50 && !(kcnt >= 20 && kcnt <= 22));
        else                bus.MBusy = 1'b0;
    end

    always @(negedge CLK_27) begin
        if (bus.lcdstrb) begin
            strb_data.push_back(bus.Lcd_data);
            strb_cyc.push_back(cyc);
            if (prev_strb) consec_err = consec_err + 1;
        end
        if (bus.done) done_cnt = done_cnt + 1;
        prev_strb = bus.lcdstrb;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, " count"}, strb_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < strb_data.size(); i++) begin
            chk($sformatf("%s byte%0d", tag, i), {24'd0, strb_data[i]}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic run_value(input logic [15:0] v, input string tag, input int gap,
                             input bit chk_lat, input bit restart);
        int  start_cyc;
        int  busy_bad;
        bit  finished;
        bit  restarted;
        strb_data.delete();
        strb_cyc.delete();
        done_cnt  = 0;
        busy_bad  = 0;
        finished  = 1'b0;
        restarted = 1'b0;
        @(negedge CLK_27);
        bus.value = v;
        bus.start = 1'b1;
        @(posedge CLK_27);
        #1 start_cyc = cyc;
        for (int i = 0; i < 4000 && !finished; i++) begin
            @(negedge CLK_27);
            if (bus.done) finished = 1'b1;
            else if (!bus.busy) busy_bad = busy_bad + 1;
            if (restart && !restarted && strb_data.size() >= 2) begin
                bus.value = 16'd9;
                bus.start = 1'b1;
                restarted = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        repeat (30) @(negedge CLK_27);
        chk({tag, " finished"}, {31'd0, finished}, 32'd1);
        chk({tag, " busy held"}, busy_bad, 32'd0);
        chk({tag, " done pulses"}, done_cnt, 32'd1);
        chk_stream(tag);
        if (chk_lat && strb_cyc.size() > 0)
            chk({tag, " first latency"}, strb_cyc[0] - start_cyc, 32'd17);
        if (gap > 0) begin
            for (int i = 1; i < strb_cyc.size(); i++)
                chk($sformatf("%s gap%0d", tag, i), strb_cyc[i] - strb_cyc[i-1], gap);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.value = '0;
        bus.MBusy = 1'b0;

        // Reset with MBusy stuck high, then a request that must stall.
        mode  = 2;
        RESET = 1'b1;
        repeat (3) @(posedge CLK_27);
        #1;
        chk("rst Lcd_data", {24'd0, bus.Lcd_data}, 32'h00);
        chk("rst lcdstrb", {31'd0, bus.lcdstrb}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        @(negedge CLK_27);
        RESET = 1'b0;
        repeat (5) @(negedge CLK_27);
        bus.value = 16'd5;
        bus.start = 1'b1;
        @(negedge CLK_27);
        bus.start = 1'b0;
        repeat (10000) @(negedge CLK_27);
        chk("stall strobes", strb_data.size(), 32'd0);
        chk("stall busy", {31'd0, bus.busy}, 32'd1);
        mode = 0;
        for (int i = 0; i < 200 && !bus.done; i++) @(negedge CLK_27);
        repeat (3) @(negedge CLK_27);
        exp_q = '{8'h58, 8'h35};
        chk_stream("stall release");
        chk("stall done", done_cnt, 32'd1);

        // Main conversions with MBusy low.
        repeat (20) @(negedge CLK_27);
        exp_q = '{8'h58, 8'h31, 8'h32, 8'h33, 8'h34};
        run_value(16'd1234, "v1234", 9, 1'b1, 1'b0);
        exp_q = '{8'h58, 8'h30};
        run_value(16'd0, "v0", 0, 1'b0, 1'b0);
        exp_q = '{8'h58, 8'h37};
        run_value(16'd7, "v7", 0, 1'b0, 1'b0);
        exp_q = '{8'h58, 8'h31, 8'h30, 8'h30, 8'h35};
        run_value(16'd1005, "v1005 restart", 0, 1'b0, 1'b1);
        exp_q = '{8'h58, 8'h2D, 8'h31, 8'h30};
        run_value(16'hFFF6, "vneg10", 0, 1'b0, 1'b0);
        exp_q = '{8'h58, 8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38};
        run_value(16'h8000, "vmin", 0, 1'b0, 1'b0);
        exp_q = '{8'h58, 8'h33, 8'h32, 8'h37, 8'h36, 8'h37};
        run_value(16'h7FFF, "vmax", 0, 1'b0, 1'b0);

        // Paced by the controller model: 50 busy cycles then 8 settle cycles.
        mode = 1;
        exp_q = '{8'h58, 8'h31, 8'h32, 8'h33, 8'h34};
        run_value(16'd1234, "model1234", 59, 1'b0, 1'b0);
        mode = 0;
        repeat (80) @(negedge CLK_27);

        // Reset abandons a sequence after its second strobe.
        strb_data.delete();
        strb_cyc.delete();
        done_cnt = 0;
        bus.value = 16'd1234;
        bus.start = 1'b1;
        @(negedge CLK_27);
        bus.start = 1'b0;
        for (int i = 0; i < 300 && strb_data.size() < 2; i++) @(negedge CLK_27);
        chk("abort two strobes", strb_data.size(), 32'd2);
        RESET = 1'b1;
        @(posedge CLK_27);
        #1;
        chk("abort lcdstrb", {31'd0, bus.lcdstrb}, 32'd0);
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort Lcd_data", {24'd0, bus.Lcd_data}, 32'h00);
        @(negedge CLK_27);
        RESET = 1'b0;
        repeat (150) @(negedge CLK_27);
        chk("abort no more strobes", strb_data.size(), 32'd2);
        chk("abort no done", done_cnt, 32'd0);

        exp_q = '{8'h58, 8'h34, 8'h32};
        run_value(16'd42, "v42", 0, 1'b0, 1'b0);

        chk("no back-to-back strobes", consec_err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
